// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory refill slice.
// Optional miss statistics are enabled with DMEM_STATS_EN.
package dmem_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam int BLOCK_W          = 128;
  localparam int WORD_W           = 32;
  localparam int DEF_MISS_LATENCY = 20;
  localparam int DEF_MEM_BLOCKS   = 4096;
endpackage

// File: rtl/d_mem_refill_if.sv
// Cache-side bus between the data cache and the refill controller.
// The cache drives the master side; the refill block is the slave.
interface d_mem_refill_if
  import dmem_pkg::*;
();
  logic [3:0]         MemtoRegM;
  logic               WE;
  logic [31:0]        A;
  logic [WORD_W-1:0]  WD;
  logic               cache_hit;
  logic [BLOCK_W-1:0] WM;
  logic               READY;
  logic               busy;

  modport master (
    output MemtoRegM, WE, A, WD, cache_hit,
    input  WM, READY, busy
  );

  modport slave (
    input  MemtoRegM, WE, A, WD, cache_hit,
    output WM, READY, busy
  );
endinterface

// File: rtl/d_mem_array.sv
// Block-wide backing store: word-granular write port, registered
// block read port whose output register is cleared by reset.
module d_mem_array
  import dmem_pkg::*;
#(
  parameter  int MEM_BLOCKS = DEF_MEM_BLOCKS,
  localparam int AW         = $clog2(MEM_BLOCKS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_we,
  input  logic [AW-1:0]      i_wr_addr,
  input  logic [1:0]         i_wsel,
  input  logic [WORD_W-1:0]  i_wd,
  input  logic               i_re,
  input  logic [AW-1:0]      i_rd_addr,
  output logic [BLOCK_W-1:0] o_rd
);
  logic [BLOCK_W-1:0] r_mem [MEM_BLOCKS];
  logic [BLOCK_W-1:0] r_rd;
  logic [6:0]         w_lsb;

  assign w_lsb = {i_wsel, 5'd0};

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_wr_addr][w_lsb +: WORD_W] <= i_wd;
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_rd <= '0;
    else if (i_re)
      r_rd <= r_mem[i_rd_addr];
  end

  assign o_rd = r_rd;
endmodule

// File: rtl/d_mem_refill.sv
// Miss-refill controller with write-through backing memory.
// Define DMEM_STATS_EN to add the saturating miss_count output.
module d_mem_refill
  import dmem_pkg::*;
#(
  parameter int MISS_LATENCY = DEF_MISS_LATENCY,
  parameter int MEM_BLOCKS   = DEF_MEM_BLOCKS
) (
  input  logic  clk,
  input  logic  rst,
  d_mem_refill_if.slave bus
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0] miss_count
`endif
);
  localparam int AW = $clog2(MEM_BLOCKS);
  localparam logic [5:0] CNT_INIT = 6'(MISS_LATENCY - 1);

  state_t          r_state, w_next;
  logic [5:0]      r_cnt, w_cnt;
  logic [AW-1:0]   r_blk, w_blk;
  logic            r_busy;
  logic            w_access, w_miss;
  logic            w_rd_en, w_wr_en;
  logic            w_start;
  logic            w_unused;

  assign w_access = (bus.MemtoRegM[1:0] == 2'b11) || bus.WE;
  assign w_miss   = w_access && !bus.cache_hit;
  assign w_wr_en  = bus.WE && (r_state == IDLE);
  assign w_unused = ^{bus.A[31:4+AW], bus.A[1:0],
                      bus.MemtoRegM[3:2]};

  always_comb begin
    w_next  = r_state;
    w_cnt   = r_cnt;
    w_blk   = r_blk;
    w_rd_en = 1'b0;
    w_start = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_miss) begin
          w_next  = FETCH;
          w_cnt   = CNT_INIT;
          w_blk   = bus.A[4 +: AW];
          w_start = 1'b1;
        end
      end
      FETCH: begin
        w_cnt = r_cnt - 6'd1;
        // a dropped access is a pipeline flush
        if (!w_access) begin
          w_next = IDLE;
        end else if (r_cnt == 6'd1) begin
          w_rd_en = 1'b1;
          w_next  = RESP;
        end
      end
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_blk   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_blk   <= w_blk;
      r_busy  <= (w_next != IDLE);
    end
  end

  d_mem_array #(
    .MEM_BLOCKS (MEM_BLOCKS)
  ) u_array (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_wr_en),
    .i_wr_addr (bus.A[4 +: AW]),
    .i_wsel    (bus.A[3:2]),
    .i_wd      (bus.WD),
    .i_re      (w_rd_en),
    .i_rd_addr (r_blk),
    .o_rd      (bus.WM)
  );

  assign bus.READY = (r_state == RESP);
  assign bus.busy  = r_busy;

`ifdef DMEM_STATS_EN
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk) begin
    if (rst)
      r_miss_cnt <= '0;
    else if (w_start && (r_miss_cnt != 32'hFFFF_FFFF))
      r_miss_cnt <= r_miss_cnt + 32'd1;
  end

  assign miss_count = r_miss_cnt;
`endif
endmodule

// File: tb/tb_d_mem_refill.sv
// Scoreboard bench for d_mem_refill: refill blocks are queued when a
// miss is driven and compared when READY pulses.
module tb_d_mem_refill;
  import dmem_pkg::*;

  localparam int L = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  logic [127:0] mm [4096];
  logic [127:0] sb [$];

  d_mem_refill_if bus ();

`ifdef DMEM_STATS_EN
  logic [31:0] miss_count;
`endif

  d_mem_refill #(
    .MISS_LATENCY (L),
    .MEM_BLOCKS   (4096)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DMEM_STATS_EN
    ,
    .miss_count (miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int blk(input logic [31:0] a);
    return int'(a[15:4]);
  endfunction

  task automatic mput(input logic [31:0] a,
                      input logic [31:0] d);
    logic [127:0] t;
    t = mm[blk(a)];
    t[{a[3:2], 5'd0} +: 32] = d;
    mm[blk(a)] = t;
  endtask

  task automatic idle_bus();
    bus.MemtoRegM = 4'd0;
    bus.WE        = 1'b0;
    bus.A         = 32'd0;
    bus.WD        = 32'd0;
    bus.cache_hit = 1'b0;
  endtask

  always @(negedge clk) begin
    if (bus.READY) begin
      if (sb.size() == 0)
        check("spurious_ready", 1'b1, 1'b0);
      else
        check("wm", bus.WM, sb.pop_front());
    end
  end

  task automatic store_hit(input logic [31:0] a,
                           input logic [31:0] d);
    bus.MemtoRegM = 4'd0;
    bus.WE        = 1'b1;
    bus.A         = a;
    bus.WD        = d;
    bus.cache_hit = 1'b1;
    mput(a, d);
    @(negedge clk);
    check("hit_busy", bus.busy, 1'b0);
    check("hit_ready", bus.READY, 1'b0);
    idle_bus();
  endtask

  task automatic run_miss(input logic [31:0] a, input bit st,
                          input logic [31:0] d, input int ab);
    logic eb, er;
    bus.MemtoRegM = st ? 4'd0 : 4'b0011;
    bus.WE        = st;
    bus.A         = a;
    bus.WD        = d;
    bus.cache_hit = 1'b0;
    if (st) mput(a, d);
    if (ab == 0) sb.push_back(mm[blk(a)]);
    exp_cnt++;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      eb = (ab != 0) ? (k <= ab) : (k <= L);
      er = (ab == 0) && (k == L);
      check($sformatf("busy_e%0d", k), bus.busy, eb);
      check($sformatf("ready_e%0d", k), bus.READY, er);
      if (k == 5) bus.A = a ^ 32'h0000_5550;
      if (ab != 0 && k == ab) idle_bus();
      if (ab == 0 && k == L) begin
        bus.cache_hit = 1'b1;
        bus.A         = a;
      end
    end
    idle_bus();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    idle_bus();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.READY, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_wm", bus.WM, 128'd0);
`ifdef DMEM_STATS_EN
    check("rst_cnt", miss_count, 32'd0);
`endif
    rst = 1'b0;

    for (int w = 0; w < 4; w++) begin
      store_hit(32'h1230 + 32'(4 * w), 32'hC0DE_0000 + 32'(w));
      store_hit(32'h0040 + 32'(4 * w), 32'h0400_0000 + 32'(w));
      store_hit(32'h0080 + 32'(4 * w), 32'h0800_0000 + 32'(w));
    end
    store_hit(32'h40, 32'hDEAD_BEEF);

    run_miss(32'h0000_1230, 1'b0, 32'd0, 0);
    run_miss(32'h0000_0040, 1'b0, 32'd0, 0);
    run_miss(32'h0000_008C, 1'b1, 32'h1234_5678, 0);
    run_miss(32'h0001_1230, 1'b0, 32'd0, 0);
    run_miss(32'h0000_1230, 1'b0, 32'd0, 10);
    run_miss(32'h0000_1230, 1'b0, 32'd0, 0);
`ifdef DMEM_STATS_EN
    check("stats_cnt", miss_count, 32'(exp_cnt));
`endif

    bus.MemtoRegM = 4'b0011;
    bus.A         = 32'h40;
    bus.cache_hit = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("rbusy_e%0d", k), bus.busy, 1'b1);
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", bus.READY, 1'b0);
    check("mid_rst_busy", bus.busy, 1'b0);
    check("mid_rst_wm", bus.WM, 128'd0);
`ifdef DMEM_STATS_EN
    check("mid_rst_cnt", miss_count, 32'd0);
`endif
    exp_cnt = 0;
    rst = 1'b0;
    idle_bus();
    repeat (3) begin
      @(negedge clk);
      check("post_rst_busy", bus.busy, 1'b0);
    end
    run_miss(32'h0000_0040, 1'b0, 32'd0, 0);

    repeat (2) @(negedge clk);
    check("sb_drain", 128'(sb.size()), 128'd0);
`ifdef DMEM_STATS_EN
    check("final_cnt", miss_count, 32'(exp_cnt));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
